data_tcm: RTL and testbench

DATA_TCM -- requirements
Module: data_tcm

---
 rtl/data_tcm.sv | 167 ++++++++++++++++
 tb/tb_data_tcm.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_tcm.sv
// Zero-wait-state data TCM on an AHB-style pipelined bus, big-endian byte lanes.
// Writes land in a posted write buffer and are committed to single-port RAM in read-free cycles.
module data_tcm #(
  parameter int unsigned OPTION_DTCM_NUM_WORDS = 1024,
  parameter logic [31:0] OPTION_DTCM_BASE      = 32'h0001_0000
) (
  input  logic        CLK,
  input  logic        RESET_I,
  input  logic [31:0] DADDR_I,
  input  logic [1:0]  DTRANS_I,
  input  logic [2:0]  DSIZE_I,
  input  logic        DWRITE_I,
  input  logic [31:0] DWDATA_I,
  output logic [31:0] DRDATA_O,
  output logic        DREADY_O,
  output logic [1:0]  DRESP_O
);

  localparam int unsigned AW = $clog2(OPTION_DTCM_NUM_WORDS);

  typedef enum logic [2:0] {IDLE, RD_DATA, WR_DATA, ERR1, ERR2} state_t;

  state_t          r_state;
  logic            r_ready;
  logic [1:0]      r_resp;
  logic [AW-1:0]   r_idx;
  logic [3:0]      r_mask;

  logic            r_buf_vld;
  logic [AW-1:0]   r_buf_idx;
  logic [3:0]      r_buf_mask;
  logic [31:0]     r_buf_data;
  logic            r_pnd_vld;
  logic [AW-1:0]   r_pnd_idx;
  logic [3:0]      r_pnd_mask;
  logic [31:0]     r_pnd_data;

  logic [31:0]     r_mem [OPTION_DTCM_NUM_WORDS];
  logic [31:0]     r_ram_q;

  logic            w_accept;
  logic            w_in_range;
  logic            w_misalign;
  logic            w_err;
  logic            w_rd_ok;
  logic [AW-1:0]   w_addr_idx;
  logic [3:0]      w_addr_mask;
  logic            w_commit_pnd;
  logic            w_commit_buf;
  logic            w_commit;
  logic [AW-1:0]   w_cm_idx;
  logic [3:0]      w_cm_mask;
  logic [31:0]     w_cm_data;
  logic [AW-1:0]   w_ram_addr;
  logic [31:0]     w_wlanes;
  logic [31:0]     w_rdata;

  function automatic logic [31:0] lanes(input logic [3:0] m);
    logic [31:0] v;
    v = '0;
    for (int unsigned b = 0; b < 4; b++) v[8*b +: 8] = {8{m[b]}};
    return v;
  endfunction

  assign DREADY_O   = RESET_I | r_ready;
  assign DRESP_O    = RESET_I ? '0 : r_resp;
  assign w_accept   = DREADY_O & DTRANS_I[1];
  assign w_in_range = (DADDR_I[31:AW+2] == OPTION_DTCM_BASE[31:AW+2]);
  assign w_misalign = ((DSIZE_I == 3'b001) & DADDR_I[0]) |
                      ((DSIZE_I == 3'b010) & (|DADDR_I[1:0]));
  assign w_err      = ~w_in_range | (DSIZE_I > 3'b010) | w_misalign;
  assign w_rd_ok    = w_accept & ~w_err & ~DWRITE_I;
  assign w_addr_idx = DADDR_I[AW+1:2];

  // Mask bit b covers DATA[8b+7:8b]; byte offset 0 is the MSB lane.
  always_comb begin
    w_addr_mask = '0;
    case (DSIZE_I)
      3'b000:  w_addr_mask = 4'b1000 >> DADDR_I[1:0];
      3'b001:  w_addr_mask = DADDR_I[1] ? 4'b0011 : 4'b1100;
      default: w_addr_mask = '1;
    endcase
  end

  // Back-to-back writes followed by a read can leave an older entry uncommitted
  // when the next write reloads the buffer; it moves to r_pnd so nothing is lost.
  assign w_commit_pnd = ~RESET_I & ~w_rd_ok & r_pnd_vld;
  assign w_commit_buf = ~RESET_I & ~w_rd_ok & ~r_pnd_vld & r_buf_vld;
  assign w_commit     = w_commit_pnd | w_commit_buf;
  assign w_cm_idx     = r_pnd_vld ? r_pnd_idx  : r_buf_idx;
  assign w_cm_mask    = r_pnd_vld ? r_pnd_mask : r_buf_mask;
  assign w_cm_data    = r_pnd_vld ? r_pnd_data : r_buf_data;
  assign w_ram_addr   = w_rd_ok ? w_addr_idx : w_cm_idx;
  assign w_wlanes     = DWDATA_I & lanes(r_mask);

  always_ff @(posedge CLK) begin
    if (w_commit) begin
      for (int unsigned b = 0; b < 4; b++)
        if (w_cm_mask[b]) r_mem[w_ram_addr][8*b +: 8] <= w_cm_data[8*b +: 8];
    end
    if (w_rd_ok) r_ram_q <= r_mem[w_ram_addr];
  end

  always_ff @(posedge CLK) begin
    if (RESET_I) begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_resp  <= 2'b00;
    end else if (r_state == ERR1) begin
      r_state <= ERR2;
      r_ready <= 1'b1;
      r_resp  <= 2'b01;
    end else if (w_accept) begin
      r_idx  <= w_addr_idx;
      r_mask <= w_addr_mask;
      if (w_err) begin
        r_state <= ERR1;
        r_ready <= 1'b0;
        r_resp  <= 2'b01;
      end else begin
        r_state <= DWRITE_I ? WR_DATA : RD_DATA;
        r_ready <= 1'b1;
        r_resp  <= 2'b00;
      end
    end else begin
      r_state <= IDLE;
      r_ready <= 1'b1;
      r_resp  <= 2'b00;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET_I) begin
      r_buf_vld <= 1'b0;
      r_pnd_vld <= 1'b0;
    end else begin
      if (w_commit_pnd) r_pnd_vld <= 1'b0;
      if (w_commit_buf) r_buf_vld <= 1'b0;
      if (r_state == WR_DATA) begin
        if (r_buf_vld && !w_commit_buf) begin
          r_pnd_vld  <= 1'b1;
          r_pnd_idx  <= r_buf_idx;
          r_pnd_mask <= r_buf_mask;
          r_pnd_data <= r_buf_data;
        end
        r_buf_vld  <= 1'b1;
        r_buf_idx  <= r_idx;
        r_buf_mask <= r_mask;
        r_buf_data <= w_wlanes;
      end
    end
  end

  // The write buffer is newer than the pending entry, so it wins per byte.
  always_comb begin
    w_rdata = r_ram_q;
    for (int unsigned b = 0; b < 4; b++) begin
      if (r_buf_vld && (r_buf_idx == r_idx) && r_buf_mask[b])
        w_rdata[8*b +: 8] = r_buf_data[8*b +: 8];
      else if (r_pnd_vld && (r_pnd_idx == r_idx) && r_pnd_mask[b])
        w_rdata[8*b +: 8] = r_pnd_data[8*b +: 8];
    end
  end

  assign DRDATA_O = ((r_state == RD_DATA) && !RESET_I) ? w_rdata : '0;

endmodule

// File: tb/tb_data_tcm.sv
// Directed self-checking bench for data_tcm: reset, zero-wait reads/writes,
// forwarding, error responses, back-to-back traffic and reset abort.
module tb_data_tcm;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam logic [1:0]  T_IDLE = 2'b00, T_BUSY = 2'b01, T_NS = 2'b10, T_SEQ = 2'b11;
  localparam logic [2:0]  SZ_B = 3'b000, SZ_H = 3'b001, SZ_W = 3'b010;

  logic        CLK = 1'b0;
  logic        RESET_I;
  logic [31:0] DADDR_I;
  logic [1:0]  DTRANS_I;
  logic [2:0]  DSIZE_I;
  logic        DWRITE_I;
  logic [31:0] DWDATA_I;
  logic [31:0] DRDATA_O;
  logic        DREADY_O;
  logic [1:0]  DRESP_O;

  int checks = 0;
  int errors = 0;

  data_tcm #(.OPTION_DTCM_NUM_WORDS(1024), .OPTION_DTCM_BASE(32'h0001_0000)) dut (
    .CLK(CLK), .RESET_I(RESET_I), .DADDR_I(DADDR_I), .DTRANS_I(DTRANS_I),
    .DSIZE_I(DSIZE_I), .DWRITE_I(DWRITE_I), .DWDATA_I(DWDATA_I),
    .DRDATA_O(DRDATA_O), .DREADY_O(DREADY_O), .DRESP_O(DRESP_O)
  );

  always #5 CLK = ~CLK;

  task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic [2:0] s,
                       input logic w, input logic [31:0] wd);
    DTRANS_I = t; DADDR_I = a; DSIZE_I = s; DWRITE_I = w; DWDATA_I = wd;
  endtask

  task automatic tick;
    @(posedge CLK); #1;
  endtask

  task automatic test_reset;
    RESET_I = 1'b1;
    drive(T_IDLE, '0, SZ_W, 1'b0, '0);
    tick; tick;
    @(negedge CLK);
    checks++;
    if (DREADY_O !== 1'b1 || DRESP_O !== 2'b00 || DRDATA_O !== 32'h0) begin
      errors++;
      $display("FAIL reset_hold: ready=%b resp=%b rdata=%h want 1/00/00000000", DREADY_O, DRESP_O, DRDATA_O);
    end
    tick;
    RESET_I = 1'b0;
    @(negedge CLK);
    checks++;
    if (DREADY_O !== 1'b1 || DRESP_O !== 2'b00 || DRDATA_O !== 32'h0) begin
      errors++;
      $display("FAIL reset_release: ready=%b resp=%b rdata=%h want 1/00/00000000", DREADY_O, DRESP_O, DRDATA_O);
    end
    tick;
  endtask

  task automatic test_write_read;
    drive(T_NS, BASE + 32'h10, SZ_W, 1'b1, '0);
    tick;
    drive(T_NS, BASE + 32'h10, SZ_W, 1'b0, 32'h1122_3344);
    @(negedge CLK);
    checks++;
    if (DREADY_O !== 1'b1 || DRESP_O !== 2'b00 || DRDATA_O !== 32'h0) begin
      errors++;
      $display("FAIL wr_dphase: ready=%b resp=%b rdata=%h want 1/00/00000000", DREADY_O, DRESP_O, DRDATA_O);
    end
    tick;
    drive(T_IDLE, '0, SZ_W, 1'b0, '0);
    @(negedge CLK);
    checks++;
    if (DREADY_O !== 1'b1 || DRESP_O !== 2'b00 || DRDATA_O !== 32'h1122_3344) begin
      errors++;
      $display("FAIL wr_rd_b2b: ready=%b resp=%b rdata=%h want 1/00/11223344", DREADY_O, DRESP_O, DRDATA_O);
    end
    tick;
  endtask

  task automatic test_byte_forward;
    drive(T_NS, BASE + 32'h11, SZ_B, 1'b1, '0);
    tick;
    drive(T_NS, BASE + 32'h10, SZ_W, 1'b0, 32'hFFAB_FFFF);
    tick;
    drive(T_IDLE, '0, SZ_W, 1'b0, '0);
    @(negedge CLK);
    checks++;
    if (DREADY_O !== 1'b1 || DRESP_O !== 2'b00 || DRDATA_O !== 32'h11AB_3344) begin
      errors++;
      $display("FAIL byte_fwd: ready=%b resp=%b rdata=%h want 1/00/11ab3344", DREADY_O, DRESP_O, DRDATA_O);
    end
    repeat (5) tick;
    drive(T_NS, BASE + 32'h10, SZ_W, 1'b0, '0);
    tick;
    drive(T_IDLE, '0, SZ_W, 1'b0, '0);
    @(negedge CLK);
    checks++;
    if (DRDATA_O !== 32'h11AB_3344 || DRESP_O !== 2'b00) begin
      errors++;
      $display("FAIL byte_ram: rdata=%h resp=%b want 11ab3344/00", DRDATA_O, DRESP_O);
    end
    tick;
  endtask

  task automatic test_halfword;
    drive(T_NS, BASE + 32'h12, SZ_H, 1'b1, '0);
    tick;
    drive(T_SEQ, BASE + 32'h13, SZ_B, 1'b0, 32'h9999_5566);
    tick;
    drive(T_IDLE, '0, SZ_W, 1'b0, '0);
    @(negedge CLK);
    checks++;
    if (DRDATA_O !== 32'h11AB_5566) begin
      errors++;
      $display("FAIL half_fwd_byte_rd: rdata=%h want 11ab5566", DRDATA_O);
    end
    repeat (2) tick;
    drive(T_NS, BASE + 32'h10, SZ_H, 1'b0, '0);
    tick;
    drive(T_IDLE, '0, SZ_W, 1'b0, '0);
    @(negedge CLK);
    checks++;
    if (DRDATA_O !== 32'h11AB_5566) begin
      errors++;
      $display("FAIL half_ram_half_rd: rdata=%h want 11ab5566", DRDATA_O);
    end
    tick;
  endtask

  task automatic test_idle_busy;
    drive(T_BUSY, BASE + 32'h10, SZ_W, 1'b1, '0);
    tick;
    drive(T_IDLE, BASE + 32'h10, SZ_W, 1'b1, 32'hDEAD_BEEF);
    @(negedge CLK);
    checks++;
    if (DREADY_O !== 1'b1 || DRESP_O !== 2'b00 || DRDATA_O !== 32'h0) begin
      errors++;
      $display("FAIL busy_ignored: ready=%b resp=%b rdata=%h want 1/00/00000000", DREADY_O, DRESP_O, DRDATA_O);
    end
    tick;
    repeat (2) tick;
    drive(T_NS, BASE + 32'h10, SZ_W, 1'b0, '0);
    tick;
    drive(T_IDLE, '0, SZ_W, 1'b0, '0);
    @(negedge CLK);
    checks++;
    if (DRDATA_O !== 32'h11AB_5566) begin
      errors++;
      $display("FAIL busy_no_write: rdata=%h want 11ab5566", DRDATA_O);
    end
    tick;
  endtask

  task automatic test_errors;
    logic [31:0] ea [5];
    logic [2:0]  es [5];
    logic        ew [5];
    ea = '{BASE + 32'h1000, BASE + 32'h1, BASE, BASE + 32'h12, BASE - 32'h4};
    es = '{SZ_W, SZ_H, 3'b011, SZ_W, SZ_W};
    ew = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      drive(T_NS, ea[i], es[i], ew[i], '0);
      tick;
      drive(T_IDLE, '0, SZ_W, 1'b0, 32'hDEAD_BEEF);
      @(negedge CLK);
      checks++;
      if (DREADY_O !== 1'b0 || DRESP_O !== 2'b01 || DRDATA_O !== 32'h0) begin
        errors++;
        $display("FAIL err%0d_cyc1: ready=%b resp=%b rdata=%h want 0/01/00000000", i, DREADY_O, DRESP_O, DRDATA_O);
      end
      tick;
      // ERR2 may accept the next transfer; the last case issues a read here.
      if (i == 4) drive(T_NS, BASE + 32'h10, SZ_W, 1'b0, '0);
      @(negedge CLK);
      checks++;
      if (DREADY_O !== 1'b1 || DRESP_O !== 2'b01) begin
        errors++;
        $display("FAIL err%0d_cyc2: ready=%b resp=%b want 1/01", i, DREADY_O, DRESP_O);
      end
      tick;
    end
    drive(T_IDLE, '0, SZ_W, 1'b0, '0);
    @(negedge CLK);
    checks++;
    if (DREADY_O !== 1'b1 || DRESP_O !== 2'b00 || DRDATA_O !== 32'h11AB_5566) begin
      errors++;
      $display("FAIL err_mem_unchanged: ready=%b resp=%b rdata=%h want 1/00/11ab5566", DREADY_O, DRESP_O, DRDATA_O);
    end
    tick;
  endtask

  task automatic test_boundary;
    drive(T_NS, BASE + 32'hFFC, SZ_W, 1'b1, '0);
    tick;
    drive(T_IDLE, '0, SZ_W, 1'b0, 32'hA5A5_5A5A);
    repeat (2) tick;
    drive(T_NS, BASE + 32'hFFC, SZ_W, 1'b0, '0);
    tick;
    drive(T_IDLE, '0, SZ_W, 1'b0, '0);
    @(negedge CLK);
    checks++;
    if (DREADY_O !== 1'b1 || DRESP_O !== 2'b00 || DRDATA_O !== 32'hA5A5_5A5A) begin
      errors++;
      $display("FAIL last_word: ready=%b resp=%b rdata=%h want 1/00/a5a55a5a", DREADY_O, DRESP_O, DRDATA_O);
    end
    tick;
  endtask

  task automatic test_back_to_back;
    localparam int N = 24;
    logic        ow [N];
    logic [11:0] oa [N];
    logic [31:0] od [N];
    ow = '{1,1,1,1, 0,0,0,0, 0,1,0,1, 0,1,0,1, 0,0,0,0, 1,1,0,0};
    oa = '{12'h40,12'h44,12'h48,12'h4C, 12'h40,12'h44,12'h48,12'h4C,
           12'h40,12'h44,12'h48,12'h4C, 12'h44,12'h40,12'h4C,12'h48,
           12'h40,12'h44,12'h48,12'h4C, 12'h40,12'h44,12'h40,12'h44};
    od = '{32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004,
           32'h1000_0001, 32'h2000_0002, 32'h3000_0003, 32'h4000_0004,
           32'h1000_0001, 32'h5151_5151, 32'h3000_0003, 32'h7373_7373,
           32'h5151_5151, 32'h6060_6060, 32'h7373_7373, 32'h8282_8282,
           32'h6060_6060, 32'h5151_5151, 32'h8282_8282, 32'h7373_7373,
           32'hE0E0_E0E0, 32'hE1E1_E1E1, 32'hE0E0_E0E0, 32'hE1E1_E1E1};
    for (int i = 0; i <= N; i++) begin
      logic [31:0] wd;
      wd = (i > 0 && ow[i-1]) ? od[i-1] : 32'h0;
      if (i < N) drive(T_NS, BASE + {20'h0, oa[i]}, SZ_W, ow[i], wd);
      else       drive(T_IDLE, '0, SZ_W, 1'b0, wd);
      if (i > 0) begin
        logic [31:0] exp;
        exp = ow[i-1] ? 32'h0 : od[i-1];
        @(negedge CLK);
        checks++;
        if (DREADY_O !== 1'b1 || DRESP_O !== 2'b00 || DRDATA_O !== exp) begin
          errors++;
          $display("FAIL b2b_op%0d: ready=%b resp=%b rdata=%h want 1/00/%h", i-1, DREADY_O, DRESP_O, DRDATA_O, exp);
        end
      end
      tick;
    end
  endtask

  task automatic test_reset_abort;
    drive(T_NS, BASE + 32'h20, SZ_W, 1'b1, '0);
    tick;
    drive(T_IDLE, '0, SZ_W, 1'b0, 32'hCAFE_F00D);
    repeat (3) tick;
    drive(T_NS, BASE + 32'h20, SZ_W, 1'b1, '0);
    tick;
    drive(T_IDLE, '0, SZ_W, 1'b0, 32'h1234_5678);
    RESET_I = 1'b1;
    @(negedge CLK);
    checks++;
    if (DREADY_O !== 1'b1 || DRESP_O !== 2'b00 || DRDATA_O !== 32'h0) begin
      errors++;
      $display("FAIL rst_wr_abort: ready=%b resp=%b rdata=%h want 1/00/00000000", DREADY_O, DRESP_O, DRDATA_O);
    end
    tick;
    RESET_I = 1'b0;
    drive(T_NS, BASE + 32'h20, SZ_W, 1'b0, '0);
    tick;
    drive(T_IDLE, '0, SZ_W, 1'b0, '0);
    @(negedge CLK);
    checks++;
    if (DREADY_O !== 1'b1 || DRESP_O !== 2'b00 || DRDATA_O !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL rst_old_value: ready=%b resp=%b rdata=%h want 1/00/cafef00d", DREADY_O, DRESP_O, DRDATA_O);
    end
    tick;
    drive(T_NS, BASE + 32'h2000, SZ_W, 1'b0, '0);
    tick;
    drive(T_IDLE, '0, SZ_W, 1'b0, '0);
    RESET_I = 1'b1;
    @(negedge CLK);
    checks++;
    if (DREADY_O !== 1'b1 || DRESP_O !== 2'b00) begin
      errors++;
      $display("FAIL rst_in_err1: ready=%b resp=%b want 1/00", DREADY_O, DRESP_O);
    end
    tick;
    RESET_I = 1'b0;
    @(negedge CLK);
    checks++;
    if (DREADY_O !== 1'b1 || DRESP_O !== 2'b00) begin
      errors++;
      $display("FAIL rst_err_aborted: ready=%b resp=%b want 1/00", DREADY_O, DRESP_O);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_byte_forward;
    test_halfword;
    test_idle_busy;
    test_errors;
    test_boundary;
    test_back_to_back;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
